// File: rtl/argmax_classifier_if.sv
// Stream interface for argmax_classifier: score beats in, one class result out.
// With ARGMAX_TOP2_EN defined, the result also carries out_margin.
interface argmax_classifier_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 10
);
    // Both channels use valid/ready: a transfer happens on a rising clk edge where
    // valid and ready are both 1. Once the sender raises valid, it holds valid and
    // the payload steady until that transfer happens.
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_class;
    logic [DATA_W-1:0] out_score;
    logic              out_len_err;
`ifdef ARGMAX_TOP2_EN
    logic [DATA_W-1:0] out_margin;
`endif

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_class, out_score, out_len_err
`ifdef ARGMAX_TOP2_EN
        , input out_margin
`endif
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_class, out_score, out_len_err
`ifdef ARGMAX_TOP2_EN
        , output out_margin
`endif
    );
endinterface

// File: rtl/argmax_classifier.sv
// Streaming argmax over NUM_CLASSES unsigned scores; ties keep the lowest index.
// Define ARGMAX_TOP2_EN to also report the winner's margin over the runner-up.
module argmax_classifier #(
    parameter int NUM_CLASSES = 1024,
    parameter int DATA_W      = 16,
    parameter int IDX_W       = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    argmax_classifier_if.slave  bus,
    output logic                dbg_state_o
);
    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_e            state_q;
    logic [IDX_W-1:0]  cnt_q;
    logic [DATA_W-1:0] best_score_q, best_score_d;
    logic [IDX_W-1:0]  best_idx_q, best_idx_d;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [IDX_W-1:0]  out_class_q;
    logic [DATA_W-1:0] out_score_q;
    logic              out_len_err_q;
    logic              accept;
    logic              at_last_idx;
    logic              final_beat;

    assign accept      = bus.in_valid && in_ready_q;
    assign at_last_idx = (cnt_q == LAST_IDX);
    assign final_beat  = bus.in_last || at_last_idx;

    // The first beat always loads, so a stale best from an earlier vector never leaks in.
    always_comb begin
        best_score_d = best_score_q;
        best_idx_d   = best_idx_q;
        if (cnt_q == '0) begin
            best_score_d = bus.in_data;
            best_idx_d   = '0;
        end else if (bus.in_data > best_score_q) begin
            best_score_d = bus.in_data;
            best_idx_d   = cnt_q;
        end
    end

`ifdef ARGMAX_TOP2_EN
    logic [DATA_W-1:0] second_q, second_d;
    logic [DATA_W-1:0] out_margin_q;

    always_comb begin
        second_d = second_q;
        if (cnt_q == '0) begin
            second_d = '0;
        end else if (bus.in_data > best_score_q) begin
            second_d = best_score_q;
        end else if (bus.in_data > second_q) begin
            second_d = bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            second_q     <= '0;
            out_margin_q <= '0;
        end else if (state_q == ACCUM && accept) begin
            second_q <= second_d;
            if (final_beat) out_margin_q <= best_score_d - second_d;
        end
    end

    assign bus.out_margin = out_margin_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ACCUM;
            cnt_q         <= '0;
            best_score_q  <= '0;
            best_idx_q    <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_class_q   <= '0;
            out_score_q   <= '0;
            out_len_err_q <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        best_score_q <= best_score_d;
                        best_idx_q   <= best_idx_d;
                        if (final_beat) begin
                            cnt_q         <= '0;
                            out_class_q   <= best_idx_d;
                            out_score_q   <= best_score_d;
                            out_len_err_q <= bus.in_last != at_last_idx;
                            in_ready_q    <= 1'b0;
                            out_valid_q   <= 1'b1;
                            state_q       <= HOLD;
                        end else begin
                            cnt_q <= cnt_q + IDX_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        state_q     <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_class   = out_class_q;
    assign bus.out_score   = out_score_q;
    assign bus.out_len_err = out_len_err_q;
    assign dbg_state_o     = (state_q == HOLD);
endmodule
